// File: rtl/rs_complex_if.sv
// rs_complex_if: dispatch, broadcast, issue and entry-view signals of the complex-unit reservation station.
interface rs_complex_if #(parameter int TAG_W = 4) ();
  logic flush;
  logic disp_valid;
  logic disp_ready;
  logic [113:0] disp_inst;
  logic [TAG_W-1:0] disp_rob_num;
  logic [TAG_W-1:0] disp_rs1_tag;
  logic [TAG_W-1:0] disp_rs2_tag;
  logic cdb0_valid;
  logic cdb1_valid;
  logic [TAG_W-1:0] cdb0_tag;
  logic [TAG_W-1:0] cdb1_tag;
  logic [31:0] cdb0_data;
  logic [31:0] cdb1_data;
  logic complex_0_issue;
  logic complex_1_issue;
  logic [113:0] rs_complex_0;
  logic [113:0] rs_complex_1;
  logic [TAG_W-1:0] rs_complex_0_entry_num;
  logic [TAG_W-1:0] rs_complex_1_entry_num;
  logic selector;
  logic [1:0] rs_count;
  modport master (
    output flush, disp_valid, disp_inst, disp_rob_num, disp_rs1_tag, disp_rs2_tag,
    output cdb0_valid, cdb1_valid, cdb0_tag, cdb1_tag, cdb0_data, cdb1_data,
    output complex_0_issue, complex_1_issue,
    input disp_ready, rs_complex_0, rs_complex_1, rs_complex_0_entry_num,
    input rs_complex_1_entry_num, selector, rs_count
  );
  modport slave (
    input flush, disp_valid, disp_inst, disp_rob_num, disp_rs1_tag, disp_rs2_tag,
    input cdb0_valid, cdb1_valid, cdb0_tag, cdb1_tag, cdb0_data, cdb1_data,
    input complex_0_issue, complex_1_issue,
    output disp_ready, rs_complex_0, rs_complex_1, rs_complex_0_entry_num,
    output rs_complex_1_entry_num, selector, rs_count
  );
endinterface

// File: rtl/rs_complex.sv
// rs_complex: two-entry reservation station for the complex execute unit with dual-CDB operand capture.
// Defining RS_COMPLEX_WAKEUP_FWD_EN forwards same-cycle broadcasts onto the entry outputs.
module rs_complex #(
  parameter int TAG_W = 4
) (
  input logic clk,
  input logic rst,
  rs_complex_if.slave bus
);
  logic [1:0] valid;
  logic [113:0] pay [2];
  logic [TAG_W-1:0] rob [2];
  logic [TAG_W-1:0] t1 [2];
  logic [TAG_W-1:0] t2 [2];
  logic sel;
  logic alloc;
  logic accept;
  logic [1:0] issue;
  logic [5:0] o_rdy;
  logic [5:0] w_rdy;
  logic [TAG_W-1:0] o_tag [6];
  logic [31:0] o_d [6];
  logic [31:0] w_d [6];
  logic [113:0] cap;
  logic [113:0] wake [2];
  logic [113:0] src [2];
  logic [113:0] view [2];
  assign bus.disp_ready = ~&valid;
  assign accept = bus.disp_valid & bus.disp_ready;
  assign alloc = valid[0];
  assign issue = {bus.complex_1_issue, bus.complex_0_issue};
  // operand slots: 0/1 dispatch op1/op2, 2/3 entry0 op1/op2, 4/5 entry1 op1/op2
  always_comb begin
    o_rdy = {pay[1][38], pay[1][5], pay[0][38], pay[0][5], bus.disp_inst[38], bus.disp_inst[5]};
    o_tag = '{bus.disp_rs1_tag, bus.disp_rs2_tag, t1[0], t2[0], t1[1], t2[1]};
    o_d = '{bus.disp_inst[37:6], bus.disp_inst[70:39], pay[0][37:6], pay[0][70:39],
            pay[1][37:6], pay[1][70:39]};
    w_rdy = o_rdy;
    for (int k = 0; k < 6; k++) begin
      w_rdy[k] = o_rdy[k] | (bus.cdb0_valid && o_tag[k] == bus.cdb0_tag)
                          | (bus.cdb1_valid && o_tag[k] == bus.cdb1_tag);
      w_d[k] = o_rdy[k] ? o_d[k] :
               (bus.cdb0_valid && o_tag[k] == bus.cdb0_tag) ? bus.cdb0_data :
               (bus.cdb1_valid && o_tag[k] == bus.cdb1_tag) ? bus.cdb1_data : o_d[k];
    end
  end
  always_comb begin
    cap = {bus.disp_inst[113:71], w_d[1], w_rdy[1], w_d[0], w_rdy[0], bus.disp_inst[4:0]};
    for (int i = 0; i < 2; i++) begin
      wake[i] = {pay[i][113:71], w_d[2*i+3], w_rdy[2*i+3], w_d[2*i+2], w_rdy[2*i+2], pay[i][4:0]};
`ifdef RS_COMPLEX_WAKEUP_FWD_EN
      src[i] = wake[i];
`else
      src[i] = pay[i];
`endif
      // unready operand data is hidden so the unit never sees stale values
      view[i] = valid[i] ? {src[i][113:71], src[i][38] ? src[i][70:39] : 32'b0, src[i][38],
                            src[i][5] ? src[i][37:6] : 32'b0, src[i][5], src[i][4:0]} : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      sel <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        pay[i] <= '0;
        rob[i] <= '0;
        t1[i] <= '0;
        t2[i] <= '0;
      end
    end else if (bus.flush) begin
      valid <= '0;
      sel <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (accept && alloc == i[0]) begin
          valid[i] <= 1'b1;
          pay[i] <= cap;
          rob[i] <= bus.disp_rob_num;
          t1[i] <= bus.disp_rs1_tag;
          t2[i] <= bus.disp_rs2_tag;
        end else if (valid[i]) begin
          if (issue[i]) valid[i] <= 1'b0;
          pay[i] <= wake[i];
        end
      end
      if (accept) sel <= alloc;
    end
  end
  assign bus.rs_complex_0 = view[0];
  assign bus.rs_complex_1 = view[1];
  assign bus.rs_complex_0_entry_num = valid[0] ? rob[0] : '0;
  assign bus.rs_complex_1_entry_num = valid[1] ? rob[1] : '0;
  assign bus.selector = sel;
  assign bus.rs_count = {1'b0, valid[0]} + {1'b0, valid[1]};
endmodule

// File: tb/tb_rs_complex.sv
// tb_rs_complex: directed steps with a scoreboard of expected post-edge entry state.
module tb_rs_complex;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rs_complex_if bus ();
  rs_complex dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic [113:0] r0;
    logic [113:0] r1;
    logic [3:0] e0;
    logic [3:0] e1;
    logic sel;
    logic [1:0] cnt;
    logic rdy;
  } exp_t;
  exp_t sb [$];
  int checks = 0;
  int fails = 0;
  function automatic logic [113:0] ent(input logic [31:0] md, input logic [5:0] op,
      input logic [4:0] ctl, input logic [31:0] o2, input logic r2, input logic [31:0] o1,
      input logic r1, input logic [4:0] wr);
    return {md, op, ctl, o2, r2, o1, r1, wr};
  endfunction
  task automatic chk(input string tag, input logic [113:0] obs, input logic [113:0] want);
    checks++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask
  task automatic idle();
    bus.flush = 0;
    bus.disp_valid = 0;
    bus.disp_inst = '0;
    bus.disp_rob_num = '0;
    bus.disp_rs1_tag = '0;
    bus.disp_rs2_tag = '0;
    bus.cdb0_valid = 0;
    bus.cdb1_valid = 0;
    bus.cdb0_tag = '0;
    bus.cdb1_tag = '0;
    bus.cdb0_data = '0;
    bus.cdb1_data = '0;
    bus.complex_0_issue = 0;
    bus.complex_1_issue = 0;
  endtask
  task automatic disp(input logic [113:0] inst, input logic [3:0] rob, input logic [3:0] a,
      input logic [3:0] b);
    bus.disp_valid = 1;
    bus.disp_inst = inst;
    bus.disp_rob_num = rob;
    bus.disp_rs1_tag = a;
    bus.disp_rs2_tag = b;
  endtask
  task automatic push(input logic [113:0] r0, input logic [113:0] r1, input logic [3:0] e0,
      input logic [3:0] e1, input logic sel, input logic [1:0] cnt, input logic rdy);
    sb.push_back('{r0: r0, r1: r1, e0: e0, e1: e1, sel: sel, cnt: cnt, rdy: rdy});
  endtask
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    idle();
    #1;
    e = sb.pop_front();
    chk({tag, ".rs0"}, bus.rs_complex_0, e.r0);
    chk({tag, ".rs1"}, bus.rs_complex_1, e.r1);
    chk({tag, ".e0"}, 114'(bus.rs_complex_0_entry_num), 114'(e.e0));
    chk({tag, ".e1"}, 114'(bus.rs_complex_1_entry_num), 114'(e.e1));
    chk({tag, ".sel"}, 114'(bus.selector), 114'(e.sel));
    chk({tag, ".cnt"}, 114'(bus.rs_count), 114'(e.cnt));
    chk({tag, ".rdy"}, 114'(bus.disp_ready), 114'(e.rdy));
  endtask
  logic [113:0] a, b, bv, bw, c, d, dv, e, ev, e1, f, fv, g, h, hv;
  initial begin
    a = ent(32'hA0A0_0001, 6'h05, 5'b00011, 32'h3, 1, 32'h10, 1, 5'd1);
    b = ent(32'hB0, 6'h11, 5'b10000, 32'hFFFF_FFFF, 0, 32'h20, 1, 5'd2);
    bv = ent(32'hB0, 6'h11, 5'b10000, 32'h0, 0, 32'h20, 1, 5'd2);
    bw = ent(32'hB0, 6'h11, 5'b10000, 32'hDEAD, 1, 32'h20, 1, 5'd2);
    c = ent(32'hC0, 6'h2C, 5'b00010, 32'h1, 1, 32'h2, 1, 5'd9);
    d = ent(32'hD0, 6'h22, 5'b01000, 32'h4, 1, 32'h1234, 0, 5'd3);
    dv = ent(32'hD0, 6'h22, 5'b01000, 32'h4, 1, 32'h55, 1, 5'd3);
    e = ent(32'hE0, 6'h3F, 5'b00100, 32'h9999, 0, 32'h7, 1, 5'd4);
    ev = ent(32'hE0, 6'h3F, 5'b00100, 32'h0, 0, 32'h7, 1, 5'd4);
    e1 = ent(32'hE0, 6'h3F, 5'b00100, 32'h1, 1, 32'h7, 1, 5'd4);
    f = ent(32'hF0, 6'h01, 5'b00001, 32'h8, 1, 32'h5, 0, 5'd5);
    fv = ent(32'hF0, 6'h01, 5'b00001, 32'h8, 1, 32'h0, 0, 5'd5);
    g = ent(32'h6, 6'h2A, 5'b11111, 32'h66, 1, 32'h61, 1, 5'd31);
    h = ent(32'h77, 6'h07, 5'b00000, 32'hAB, 1, 32'hCD, 0, 5'd12);
    hv = ent(32'h77, 6'h07, 5'b00000, 32'hAB, 1, 32'h0, 0, 5'd12);
    idle();
    rst = 1;
    push('0, '0, 0, 0, 0, 0, 1);
    tick("reset");
    rst = 0;
    disp(a, 4'h2, 4'h0, 4'h0);
    push(a, '0, 2, 0, 0, 1, 1);
    tick("disp_a");
    disp(b, 4'h3, 4'h7, 4'h7);
    push(a, bv, 2, 3, 1, 2, 0);
    tick("disp_b");
    bus.cdb1_valid = 1;
    bus.cdb1_tag = 4'h7;
    bus.cdb1_data = 32'hDEAD;
    disp(c, 4'hE, 4'h0, 4'h0);
`ifdef RS_COMPLEX_WAKEUP_FWD_EN
    #1;
    chk("fwd_b", bus.rs_complex_1, bw);
`endif
    push(a, bw, 2, 3, 1, 2, 0);
    tick("wake_full");
    bus.complex_0_issue = 1;
    disp(c, 4'hE, 4'h0, 4'h0);
    push('0, bw, 0, 3, 1, 1, 1);
    tick("issue_disp");
    disp(d, 4'h5, 4'h9, 4'h0);
    bus.cdb0_valid = 1;
    bus.cdb0_tag = 4'h9;
    bus.cdb0_data = 32'h55;
    push(dv, bw, 5, 3, 0, 2, 0);
    tick("disp_capture");
    bus.complex_0_issue = 1;
    bus.complex_1_issue = 1;
    push('0, '0, 0, 0, 0, 0, 1);
    tick("issue_both");
    disp(e, 4'h6, 4'h0, 4'h4);
    push(ev, '0, 6, 0, 0, 1, 1);
    tick("disp_e");
    disp(f, 4'h8, 4'hA, 4'h0);
    push(ev, fv, 6, 8, 1, 2, 0);
    tick("disp_f");
    bus.cdb0_valid = 1;
    bus.cdb0_tag = 4'h4;
    bus.cdb0_data = 32'h1;
    bus.cdb1_valid = 1;
    bus.cdb1_tag = 4'h4;
    bus.cdb1_data = 32'h2;
    push(e1, fv, 6, 8, 1, 2, 0);
    tick("cdb_prio");
    bus.complex_1_issue = 1;
    bus.cdb0_valid = 1;
    bus.cdb0_tag = 4'hA;
    bus.cdb0_data = 32'h77;
    push(e1, '0, 6, 0, 1, 1, 1);
    tick("issue_wake");
    bus.complex_1_issue = 1;
    push(e1, '0, 6, 0, 1, 1, 1);
    tick("issue_invalid");
    disp(g, 4'h1, 4'h0, 4'h0);
    push(e1, g, 6, 1, 1, 2, 0);
    tick("disp_g");
    bus.flush = 1;
    disp(h, 4'hC, 4'h2, 4'h0);
    push('0, '0, 0, 0, 0, 0, 1);
    tick("flush");
    disp(h, 4'hC, 4'h2, 4'h0);
    push(hv, '0, 12, 0, 0, 1, 1);
    tick("disp_h");
    rst = 1;
    bus.cdb0_valid = 1;
    bus.cdb0_tag = 4'h2;
    bus.cdb0_data = 32'h5;
    push('0, '0, 0, 0, 0, 0, 1);
    tick("reset_mid");
    rst = 0;
    push('0, '0, 0, 0, 0, 0, 1);
    tick("after_reset");
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/rs_complex.md
Name: rs_complex

Overview:
- Two-entry reservation station feeding the complex execute unit.
- Accepts one dispatched instruction per cycle and captures operands from two result broadcast buses.
- Presents both entries in the 114-bit packed format the complex execute unit consumes, plus a selector marking the newer entry.
- Frees an entry when the execute unit signals issue.

Parameters:
- TAG_W, 4: ROB tag width; the packed entry format requires the default.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  mispredict flush; clears all entries next edge.
- disp_valid  input  1  dispatch request.
- disp_inst  input  114  packed entry:
  - [113:82] memdata, [81:76] aluop, [75] memwrite, [74] memread, [73] memtoreg, [72] branch, [71] regwrite.
  - [70:39] op2, [38] op2 ready, [37:6] op1, [5] op1 ready, [4:0] wrAddr.
- disp_rob_num  input  4  ROB tag of the dispatched instruction.
- disp_rs1_tag  input  4  producer tag for op1; used only when bit 5 = 0.
- disp_rs2_tag  input  4  producer tag for op2; used only when bit 38 = 0.
- disp_ready  output  1  at least one entry free; combinational from state.
- cdb0_valid, cdb1_valid  input  1  broadcast valid.
- cdb0_tag, cdb1_tag  input  4  broadcast ROB tag.
- cdb0_data, cdb1_data  input  32  broadcast result.
- complex_0_issue, complex_1_issue  input  1  execute unit consumed entry 0/1 this cycle.
- rs_complex_0, rs_complex_1  output  114  entry contents in packed format.
- rs_complex_0_entry_num, rs_complex_1_entry_num  output  4  entry ROB tags.
- selector  output  1  index of the most recently allocated entry (the newer one).
- rs_count  output  2  number of valid entries (0..2).

Behaviour:
- State per entry: valid, 114-bit payload, rob_num, rs1_tag, rs2_tag.
- Outputs for an invalid entry:
  - packed output and entry_num are all-zero, so both ready bits read 0.
  - For a valid entry, an operand field whose ready bit is 0 reads 32'b0.
- Reset (rst=1 at an edge):
  - all valid <= 0, selector <= 0, payloads <= 0.
  - Outputs then read zero, disp_ready=1, rs_count=0.
  - Reset mid-operation discards all entries, including in-flight wakeups.
- Priority: rst > flush > issue/wakeup/dispatch.
  - flush clears all valid bits and sets selector to 0.
  - A dispatch in the flush cycle is dropped.
- Dispatch:
  - Accepted when disp_valid && disp_ready; an accepted instruction is written to the lowest-index free entry at the next edge.
  - selector <= allocated index.
  - disp_ready is computed from current state only, so an entry freed by an issue in the same cycle is not reusable until the next cycle.
  - disp_valid while full is ignored; dispatch is responsible for stalling.
- Dispatch-cycle capture:
  - A dispatched operand with ready = 0 whose tag matches a valid broadcast in the same cycle is stored with that data and ready = 1.
- Wakeup:
  - Each valid entry operand with ready = 0 and tag == cdbX_tag with cdbX_valid captures cdbX_data and sets ready at the next edge.
  - If both buses match, cdb0 wins.
  - Operands already ready never change.
- Issue:
  - complex_i_issue on a valid entry clears that entry's valid at the next edge.
  - Issue on an invalid entry is ignored.
  - Both issue inputs high frees both entries.
  - Issue and wakeup on the same entry in the same cycle: issue wins, entry freed.
- Selector is unchanged by issue or wakeup; it changes only on allocation, flush or reset.
- rs_count = valid0 + valid1, registered state.
- Latency:
  - Dispatch to visible entry: 1 cycle.
  - Broadcast to ready bit visible: 1 cycle (see optional feature).

Optional Feature:
- Macro: RS_COMPLEX_WAKEUP_FWD_EN.
- Defined:
  - The packed outputs forward same-cycle broadcasts combinationally.
  - A matching unready operand reads cdb data with ready = 1 in the broadcast cycle, so it is issuable with zero wakeup latency.
  - Stored state still updates at the next edge as normal.
- Undefined: outputs reflect registered state only, with 1-cycle wakeup latency.

Test Plan:
- Reset then dispatch disp_inst with aluop 6'h05, op1=32'h10 ready, op2=32'h3 ready, rob 4'h2:
  - next cycle rs_complex_0 carries those fields with bits 5 and 38 = 1, entry_num = 2, selector = 0, rs_count = 1, disp_ready = 1.
- Dispatch rob 3 with op2 unready (tag 4'h7), then cdb1 valid, tag 7, data 32'hDEAD:
  - entry 1 op2 = 32'hDEAD, bit 38 = 1 one cycle after the broadcast (same cycle with RS_COMPLEX_WAKEUP_FWD_EN).
- Fill both entries:
  - disp_ready = 0; a further disp_valid is ignored.
  - Assert complex_0_issue together with disp_valid: entry 0 is freed, the new instruction is not accepted, disp_ready = 1 next cycle.
- Dispatch op1 unready (tag 4'h9) in the same cycle cdb0 broadcasts tag 9, data 32'h55:
  - entry stored with op1 = 32'h55, bit 5 = 1.
- Two valid entries, then flush together with disp_valid:
  - next cycle both outputs are zero, rs_count = 0, selector = 0, dispatch dropped.
- cdb0 and cdb1 both tag 4, data 1 and 2, for an entry waiting on tag 4:
  - operand captures 1 (cdb0 priority).
